fetch_stage: RTL and testbench

Instruction-fetch stage and IF/ID pipeline register of the 5-stage MIPS pipeline. Holds the PC, drives the instruction-memory address, and captures the fetched word and its PC into the IF/ID register. That register feeds the decode-stage control unit's `opcode`/`func`. The block consumes the control unit's `npcOp` together with the decode comparator's `isRsRtEq`, and redirects fetch on taken branches and jumps resolved in ID.

---
 rtl/fetch_stage_pkg.sv | 18 +
 rtl/fetch_stage_if.sv | 28 ++
 rtl/fetch_stage_next_pc.sv | 52 +++++
 rtl/fetch_stage.sv | 63 ++++++
 tb/tb_fetch_stage.sv | 149 ++++++++++++++
 5 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared encodings for the fetch stage: next-PC operations, branch opcodes
// and the nop word used to fill IF/ID bubbles.
package fetch_stage_pkg;

  localparam int NPC_OP_LENGTH = 2;

  typedef enum logic [NPC_OP_LENGTH-1:0] {
    NPC_PC4    = 2'b00,
    NPC_JUMP   = 2'b01,
    NPC_BRANCH = 2'b10,
    NPC_RSVD   = 2'b11
  } npc_op_e;

  localparam logic [5:0]  OP_BEQ = 6'b000100;
  localparam logic [5:0]  OP_BNE = 6'b000101;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: instruction memory port, control/hazard inputs and the
// IF/ID register outputs. The slave side is the fetch stage itself.
interface fetch_stage_if;
  import fetch_stage_pkg::*;

  logic [31:0]              imem_addr;
  logic [31:0]              imem_rdata;
  logic [NPC_OP_LENGTH-1:0] npcOp;
  logic                     isRsRtEq;
  logic                     stallF;
  logic                     stallD;
  logic [31:0]              pcF;
  logic [31:0]              instrD;
  logic [31:0]              pcD;
  logic                     validD;
  logic                     redirectD;

  modport master (
    input  imem_addr, pcF, instrD, pcD, validD, redirectD,
    output imem_rdata, npcOp, isRsRtEq, stallF, stallD
  );

  modport slave (
    output imem_addr, pcF, instrD, pcD, validD, redirectD,
    input  imem_rdata, npcOp, isRsRtEq, stallF, stallD
  );

endinterface

// File: rtl/fetch_stage_next_pc.sv
// Combinational next-PC logic: branch/jump targets, branch decision,
// redirect flag and the PC to load on the next edge.
module next_pc
  import fetch_stage_pkg::*;
(
  input  logic [31:0]              i_pcF,
  input  logic [31:0]              i_pcD,
  input  logic [31:0]              i_instrD,
  input  logic                     i_validD,
  input  logic [NPC_OP_LENGTH-1:0] i_npcOp,
  input  logic                     i_isRsRtEq,
  input  logic                     i_stallF,
  input  logic                     i_stallD,
  output logic                     o_redirectD,
  output logic [31:0]              o_nextPc
);

  logic [31:0] w_pcDPlus4;
  logic [31:0] w_branchTarget;
  logic [31:0] w_jumpTarget;
  logic [5:0]  w_opcode;
  logic        w_isJump;
  logic        w_branchTaken;

  assign w_opcode       = i_instrD[31:26];
  assign w_pcDPlus4     = i_pcD + 32'd4;
  assign w_branchTarget = w_pcDPlus4 + {{14{i_instrD[15]}}, i_instrD[15:0], 2'b00};
  assign w_jumpTarget   = {w_pcDPlus4[31:28], i_instrD[25:0], 2'b00};
  assign w_isJump       = (i_npcOp == NPC_JUMP);

  always_comb begin
    w_branchTaken = 1'b0;
    if (i_npcOp == NPC_BRANCH) begin
      if (w_opcode == OP_BEQ)
        w_branchTaken = i_isRsRtEq;
      else if (w_opcode == OP_BNE)
        w_branchTaken = !i_isRsRtEq;
    end
  end

  // A stalled ID must not redirect: its operands may not be forwarded yet.
  assign o_redirectD = i_validD && !i_stallD && (w_isJump || w_branchTaken);

  always_comb begin
    o_nextPc = i_pcF + 32'd4;
    if (o_redirectD)
      o_nextPc = w_isJump ? w_jumpTarget : w_branchTarget;
    else if (i_stallF)
      o_nextPc = i_pcF;
  end

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: PC register, instruction-memory address and
// the IF/ID pipeline register, with ID-resolved branch/jump redirect.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic          clk,
  input  logic          rst,
  fetch_stage_if.slave  io_bus
);

  logic [31:0] r_pcF;
  logic [31:0] r_instrD;
  logic [31:0] r_pcD;
  logic        r_validD;
  logic        w_redirectD;
  logic [31:0] w_nextPc;

  next_pc u_next_pc (
    .i_pcF       (r_pcF),
    .i_pcD       (r_pcD),
    .i_instrD    (r_instrD),
    .i_validD    (r_validD),
    .i_npcOp     (io_bus.npcOp),
    .i_isRsRtEq  (io_bus.isRsRtEq),
    .i_stallF    (io_bus.stallF),
    .i_stallD    (io_bus.stallD),
    .o_redirectD (w_redirectD),
    .o_nextPc    (w_nextPc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pcF    <= RESET_PC;
      r_instrD <= NOP_INSTR;
      r_pcD    <= 32'h0;
      r_validD <= 1'b0;
    end else begin
      r_pcF <= w_nextPc;
      // The wrong-path word fetched alongside a redirect is squashed here.
      if (!io_bus.stallD) begin
        if (w_redirectD) begin
          r_instrD <= NOP_INSTR;
          r_pcD    <= 32'h0;
          r_validD <= 1'b0;
        end else begin
          r_instrD <= io_bus.imem_rdata;
          r_pcD    <= r_pcF;
          r_validD <= 1'b1;
        end
      end
    end
  end

  assign io_bus.imem_addr = r_pcF;
  assign io_bus.pcF       = r_pcF;
  assign io_bus.instrD    = r_instrD;
  assign io_bus.pcD       = r_pcD;
  assign io_bus.validD    = r_validD;
  assign io_bus.redirectD = w_redirectD;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset, free-run, BEQ/BNE/J redirects,
// stalled branch and reset during a redirect, with hand-computed results.
module tb_fetch_stage;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  fetch_stage_if bus ();

  fetch_stage #(.RESET_PC(32'h0000_3000)) dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic [1:0] npcOp, input logic eq,
                               input logic stF, input logic stD,
                               input logic [31:0] rdata);
    bus.npcOp      = npcOp;
    bus.isRsRtEq   = eq;
    bus.stallF     = stF;
    bus.stallD     = stD;
    bus.imem_rdata = rdata;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    applyStimulus(2'b00, 1'b0, 1'b0, 1'b0, 32'h0);
    stepClock();
    stepClock();
    checkOutput("rst_pcF", bus.pcF, 32'h3000);
    checkOutput("rst_instrD", bus.instrD, 32'h0);
    checkOutput("rst_pcD", bus.pcD, 32'h0);
    checkOutput("rst_validD", {31'b0, bus.validD}, 32'h0);
    checkOutput("rst_redirect", {31'b0, bus.redirectD}, 32'h0);

    // Free run: addi at 0x3000, BEQ imm=3 at 0x3004
    rst = 1'b0;
    applyStimulus(2'b00, 1'b0, 1'b0, 1'b0, 32'h2001_0001);
    checkOutput("run_addr0", bus.imem_addr, 32'h3000);
    stepClock();
    checkOutput("run_addr1", bus.imem_addr, 32'h3004);
    checkOutput("run_pcD0", bus.pcD, 32'h3000);
    checkOutput("run_valid0", {31'b0, bus.validD}, 32'h1);
    applyStimulus(2'b00, 1'b0, 1'b0, 1'b0, 32'h1000_0003);
    stepClock();
    checkOutput("run_addr2", bus.imem_addr, 32'h3008);
    checkOutput("run_instrD1", bus.instrD, 32'h1000_0003);

    // BEQ taken: target 0x3004+4+12 = 0x3014, 0x3008 squashed
    applyStimulus(2'b10, 1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF);
    checkOutput("beq_redirect", {31'b0, bus.redirectD}, 32'h1);
    stepClock();
    checkOutput("beq_pcF", bus.pcF, 32'h3014);
    checkOutput("beq_bubble_valid", {31'b0, bus.validD}, 32'h0);
    checkOutput("beq_bubble_instr", bus.instrD, 32'h0);
    checkOutput("beq_bubble_redir", {31'b0, bus.redirectD}, 32'h0);

    // BNE imm=-1 at 0x3014, not taken when equal
    applyStimulus(2'b00, 1'b0, 1'b0, 1'b0, 32'h1400_FFFF);
    stepClock();
    checkOutput("bne_pcD", bus.pcD, 32'h3014);
    applyStimulus(2'b10, 1'b1, 1'b0, 1'b0, 32'h1400_FFFF);
    checkOutput("bne_nt_redirect", {31'b0, bus.redirectD}, 32'h0);
    stepClock();
    checkOutput("bne_nt_pcF", bus.pcF, 32'h301C);
    checkOutput("bne_nt_pcD", bus.pcD, 32'h3018);

    // BNE at 0x3018 taken: self-loop target 0x3018
    applyStimulus(2'b10, 1'b0, 1'b0, 1'b0, 32'hBAD0_0001);
    checkOutput("bne_t_redirect", {31'b0, bus.redirectD}, 32'h1);
    stepClock();
    checkOutput("bne_t_pcF", bus.pcF, 32'h3018);
    checkOutput("bne_t_valid", {31'b0, bus.validD}, 32'h0);

    // J index 0xC04 fetched at 0x3018 -> target 0x0000_3010
    applyStimulus(2'b00, 1'b0, 1'b0, 1'b0, 32'h0800_0C04);
    stepClock();
    checkOutput("j_instrD", bus.instrD, 32'h0800_0C04);
    applyStimulus(2'b01, 1'b0, 1'b0, 1'b0, 32'hBAD0_0002);
    checkOutput("j_redirect", {31'b0, bus.redirectD}, 32'h1);
    stepClock();
    checkOutput("j_pcF", bus.pcF, 32'h3010);
    checkOutput("j_valid", {31'b0, bus.validD}, 32'h0);

    // Taken BEQ at 0x3010 held by a 3-cycle stall, target 0x3020
    applyStimulus(2'b00, 1'b0, 1'b0, 1'b0, 32'h1000_0003);
    stepClock();
    applyStimulus(2'b10, 1'b1, 1'b1, 1'b1, 32'h2003_0003);
    checkOutput("stall_redirect0", {31'b0, bus.redirectD}, 32'h0);
    stepClock();
    stepClock();
    stepClock();
    checkOutput("stall_pcF", bus.pcF, 32'h3014);
    checkOutput("stall_pcD", bus.pcD, 32'h3010);
    checkOutput("stall_instrD", bus.instrD, 32'h1000_0003);
    checkOutput("stall_valid", {31'b0, bus.validD}, 32'h1);
    checkOutput("stall_redirect3", {31'b0, bus.redirectD}, 32'h0);
    applyStimulus(2'b10, 1'b1, 1'b0, 1'b0, 32'h2003_0003);
    checkOutput("release_redirect", {31'b0, bus.redirectD}, 32'h1);
    stepClock();
    checkOutput("release_pcF", bus.pcF, 32'h3020);
    checkOutput("release_valid", {31'b0, bus.validD}, 32'h0);
    applyStimulus(2'b00, 1'b0, 1'b0, 1'b0, 32'h2004_0004);
    stepClock();
    checkOutput("target_pcD", bus.pcD, 32'h3020);
    checkOutput("target_instrD", bus.instrD, 32'h2004_0004);
    checkOutput("target_pcF", bus.pcF, 32'h3024);

    // Reset asserted in the same cycle as a taken BEQ at 0x3024
    applyStimulus(2'b00, 1'b0, 1'b0, 1'b0, 32'h1000_0003);
    stepClock();
    applyStimulus(2'b10, 1'b1, 1'b0, 1'b0, 32'hBAD0_0003);
    checkOutput("rst_mid_redirect", {31'b0, bus.redirectD}, 32'h1);
    rst = 1'b1;
    stepClock();
    checkOutput("rst_mid_pcF", bus.pcF, 32'h3000);
    checkOutput("rst_mid_valid", {31'b0, bus.validD}, 32'h0);
    checkOutput("rst_mid_pcD", bus.pcD, 32'h0);
    checkOutput("rst_mid_instrD", bus.instrD, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
